// File: rtl/adder4_rr_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit adder among N_REQ requesters.
// Define ADDER4_ARB_STATS_EN to add the carry_count/grant_count statistics outputs.
module adder4_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [4*N_REQ-1:0] req_a,
  input  logic [4*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  input  logic [4:0]         add_sum,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [4:0]         rsp_sum,
  output logic               busy
`ifdef ADDER4_ARB_STATS_EN
  ,
  output logic [7:0]         carry_count,
  output logic [7:0]         grant_count
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] id;
  logic            grant_found;
  logic            accept;
  logic            handshake;
  logic [3:0]      a_arr [N_REQ];
  logic [3:0]      b_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign a_arr[k] = req_a[4*k +: 4];
    assign b_arr[k] = req_b[4*k +: 4];
  end

  // Requester index reached 'step' positions after 'base', wrapping at N_REQ.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int step);
    return ID_W'((int'(base) + step) % N_REQ);
  endfunction

  // NOTE: every variable written in always_comb gets a default first, otherwise
  // paths that skip an assignment infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!grant_found && req_valid[rr_index(last_grant, i)]) begin
        grant_found = 1'b1;
        grant       = rr_index(last_grant, i);
      end
    end
  end

  assign accept    = (state == IDLE) && grant_found;
  assign handshake = (state == RESP) && rsp_valid && rsp_ready;
  assign req_ready = accept ? (N_REQ'(1) << grant) : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_found) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // add_a/add_b double as the registered operand latch, so they hold between operations.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      id         <= '0;
      add_a      <= '0;
      add_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        add_a      <= a_arr[grant];
        add_b      <= b_arr[grant];
        id         <= grant;
        last_grant <= grant;
      end
      if (state == ISSUE) begin
        rsp_sum   <= add_sum;
        rsp_id    <= id;
        rsp_valid <= 1'b1;
      end
      if (handshake) rsp_valid <= 1'b0;
    end
  end

`ifdef ADDER4_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_count <= '0;
      grant_count <= '0;
    end else begin
      if (handshake && rsp_sum[4] && carry_count != 8'hFF) carry_count <= carry_count + 8'd1;
      if (accept) grant_count <= grant_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder4_rr_arbiter.sv
// Scoreboard bench for adder4_rr_arbiter: expected responses queued at stimulus time,
// compared when the response handshake is observed.
module tb_adder4_rr_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [4:0]      sum;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [4*N_REQ-1:0] req_a;
  logic [4*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic [3:0]         add_a;
  logic [3:0]         add_b;
  logic [4:0]         add_sum;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [4:0]         rsp_sum;
  logic               busy;
`ifdef ADDER4_ARB_STATS_EN
  logic [7:0]         carry_count;
  logic [7:0]         grant_count;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // The shared adder that the arbiter drives.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  adder4_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
`ifdef ADDER4_ARB_STATS_EN
    ,
    .carry_count (carry_count),
    .grant_count (grant_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Response monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
      end
    end
  end

  task automatic push_exp(input int k, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.id  = ID_W'(k);
    e.sum = 5'(a) + 5'(b);
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int k, output int at_cyc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    check("grant", 32'(req_ready), 32'(1) << k);
    at_cyc = cyc;
  endtask

  // Drive one request; returns just after the accept edge (DUT in ISSUE).
  task automatic do_txn(input int k, input logic [3:0] a, input logic [3:0] b, input bit expect_rsp);
    int gc;
    if (expect_rsp) push_exp(k, a, b);
    @(posedge clk); #1;
    req_a[4*k +: 4] = a;
    req_b[4*k +: 4] = b;
    req_valid       = '0;
    req_valid[k]    = 1'b1;
    wait_grant(k, gc);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int gc [5];
    int gtmp;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Single requester with two-cycle latency
    do_txn(0, 4'd3, 4'd4, 1'b1);
    @(negedge clk);
    check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_add_a", 32'(add_a), 32'd3);
    check("issue_add_b", 32'(add_b), 32'd4);
    check("issue_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Carry out: 15 + 15 = 30
    do_txn(2, 4'd15, 4'd15, 1'b1);
    drain();

    // Reset during ISSUE discards the operation
    do_txn(0, 4'd5, 4'd6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_add_a", 32'(add_a), 32'd0);
    check("mid_rst_add_b", 32'(add_b), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1, 4'd2, 4'd9, 1'b1);
    drain();

    // Round-robin from a fresh reset: 0,1,2,3,0 spaced 3 cycles apart
    apply_reset();
    @(posedge clk); #1;
    for (int k = 0; k < N_REQ; k++) begin
      req_a[4*k +: 4] = 4'(k + 1);
      req_b[4*k +: 4] = 4'(2*k + 3);
    end
    for (int j = 0; j < 5; j++) push_exp(j % N_REQ, 4'((j % N_REQ) + 1), 4'(2*(j % N_REQ) + 3));
    req_valid = '1;
    for (int j = 0; j < 5; j++) begin
      wait_grant(j % N_REQ, gc[j]);
      if (j > 0) check("rr_spacing", 32'(gc[j] - gc[j-1]), 32'd3);
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Backpressure: response held while rsp_ready is low
    rsp_ready = 1'b0;
    req_a[7:4]  = 4'd6;  req_b[7:4]  = 4'd7;
    req_a[11:8] = 4'd9;  req_b[11:8] = 4'd5;
    push_exp(1, 4'd6, 4'd7);
    push_exp(2, 4'd9, 4'd5);
    @(posedge clk); #1;
    req_valid = 4'b0110;
    wait_grant(1, gtmp);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_sum", 32'(rsp_sum), 32'd13);
      check("bp_rsp_id", 32'(rsp_id), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Exhaustive operands through requester 3
    apply_reset();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_txn(3, 4'(a), 4'(b), 1'b1);
    drain();
    @(negedge clk);
    check("final_idle_busy", 32'(busy), 32'd0);
`ifdef ADDER4_ARB_STATS_EN
    check("carry_count", 32'(carry_count), 32'd120);
    check("grant_count", 32'(grant_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
